skein_core_sequencer: RTL and testbench

Control FSM that drives one Skein-1024 `core` instance through a complete nonce evaluation. It runs a message block under the constant key, then an output block under the chained key, at one MIX or one subkey word per cycle. It generates every `core` control input: word/pair index, operand selects, rotation constants, output write masks, subkey index, tweak words and register write strobes. It sits between the nonce source / top-level scheduler (start/done handshake) and the `core` datapath.

---
 rtl/skein_pkg.sv | 58 +++++
 rtl/mix_schedule_rom.sv | 22 ++
 rtl/skein_core_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_skein_core_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/skein_pkg.sv
// rtl/skein_pkg.sv - Shared constants, state encoding and output bundle for the Skein-1024 core sequencer
package skein_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_INJECT = 3'd2,
    ST_ILATCH = 3'd3,
    ST_MIX    = 3'd4,
    ST_MLATCH = 3'd5,
    ST_FEED   = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam int BLOCK_CYCLES = 1079;
  localparam logic [4:0] LAST_SUBKEY = 5'd20;

  // Threefish-1024 rotation constants, indexed [round mod 8][pair]
  localparam logic [5:0] R [8][8] = '{
    '{6'd24, 6'd13, 6'd8,  6'd47, 6'd8,  6'd17, 6'd22, 6'd37},
    '{6'd38, 6'd19, 6'd10, 6'd55, 6'd49, 6'd18, 6'd23, 6'd52},
    '{6'd33, 6'd4,  6'd51, 6'd13, 6'd34, 6'd41, 6'd59, 6'd17},
    '{6'd5,  6'd20, 6'd48, 6'd41, 6'd47, 6'd28, 6'd16, 6'd25},
    '{6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30},
    '{6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41},
    '{6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25},
    '{6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20}
  };

  localparam logic [3:0] PI_INV [16] = '{
    4'd0, 4'd15, 4'd2, 4'd11, 4'd6, 4'd13, 4'd4, 4'd9,
    4'd14, 4'd1, 4'd8, 4'd5, 4'd10, 4'd3, 4'd12, 4'd7
  };

  // {T1, T0}: single first+final block of type MSG (128 bytes) and OUT (8 bytes)
  localparam logic [127:0] TWEAK_MSG = {64'hF000_0000_0000_0000, 64'h0000_0000_0000_0080};
  localparam logic [127:0] TWEAK_OUT = {64'hFF00_0000_0000_0000, 64'h0000_0000_0000_0008};

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        nonce_advance;
    logic        input_register_write;
    logic [3:0]  word;
    logic        x0_key_select;
    logic [1:0]  x1_tweak_subkey_select;
    logic [63:0] tweak_word;
    logic [5:0]  rotate_constant;
    logic [15:0] y1_select;
    logic [15:0] output_register_write;
    logic        key_register_write;
    logic        hash_mode;
    logic        subkey_write;
    logic        output_register_plaintext_select;
    logic [4:0]  subkey;
  } seq_out_t;

endpackage

// File: rtl/mix_schedule_rom.sv
// rtl/mix_schedule_rom.sv - Per-pair MIX schedule: rotation constant and permuted write/Y1 masks
module mix_schedule_rom
  import skein_pkg::*;
(
  input  logic [2:0]  i_round,
  input  logic [2:0]  i_pair,
  output logic [5:0]  o_rotate,
  output logic [15:0] o_write_mask,
  output logic [15:0] o_y1_mask
);

  logic [3:0] w_y0_slot;
  logic [3:0] w_y1_slot;

  // The word permutation is folded into where each MIX result is written back
  assign w_y0_slot    = PI_INV[{i_pair, 1'b0}];
  assign w_y1_slot    = PI_INV[{i_pair, 1'b1}];
  assign o_rotate     = R[i_round][i_pair];
  assign o_y1_mask    = 16'd1 << w_y1_slot;
  assign o_write_mask = (16'd1 << w_y0_slot) | (16'd1 << w_y1_slot);

endmodule

// File: rtl/skein_core_sequencer.sv
// rtl/skein_core_sequencer.sv - Control FSM stepping one Skein-1024 core through message and output blocks
module skein_core_sequencer
  import skein_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        clear_best_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        nonce_advance_o,
  output logic        input_register_write_o,
  output logic [3:0]  word_o,
  output logic        x0_key_select_o,
  output logic [1:0]  x1_tweak_subkey_select_o,
  output logic [63:0] tweak_word_o,
  output logic [5:0]  rotate_constant_o,
  output logic [15:0] Y1_select_o,
  output logic [15:0] output_register_write_o,
  output logic        key_register_write_o,
  output logic        hash_mode_o,
  output logic        subkey_write_o,
  output logic        output_register_plaintext_select_o,
  output logic [4:0]  subkey_o,
  output logic        reset_best_nonce_o
);

  state_t      r_state, w_state_nxt;
  logic        r_blk, w_blk_nxt;
  logic [4:0]  r_s, w_s_nxt;
  logic [6:0]  r_d, w_d_nxt, w_d_inc;
  logic [3:0]  r_idx, w_idx_nxt;
  seq_out_t    r_out, w_out_nxt;
  logic        r_reset_best;
  logic [5:0]  w_rot;
  logic [15:0] w_wmask, w_y1mask;
  logic [127:0] w_tweak;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_blk        <= 1'b0;
      r_s          <= '0;
      r_d          <= '0;
      r_idx        <= '0;
      r_out        <= '0;
      r_reset_best <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_blk        <= w_blk_nxt;
      r_s          <= w_s_nxt;
      r_d          <= w_d_nxt;
      r_idx        <= w_idx_nxt;
      r_out        <= w_out_nxt;
      r_reset_best <= clear_best_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blk_nxt   = r_blk;
    w_s_nxt     = r_s;
    w_d_nxt     = r_d;
    w_idx_nxt   = r_idx;
    w_d_inc     = r_d + 7'd1;
    case (r_state)
      ST_IDLE: if (start_i) begin
        w_state_nxt = ST_LOAD;
        w_blk_nxt   = 1'b0;
      end
      ST_LOAD: begin
        w_state_nxt = ST_INJECT;
        w_s_nxt     = '0;
        w_d_nxt     = '0;
        w_idx_nxt   = '0;
      end
      ST_INJECT: begin
        w_idx_nxt = r_idx + 4'd1;
        if (r_idx == 4'd15) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_ILATCH;
        end
      end
      ST_ILATCH: w_state_nxt = (r_s == LAST_SUBKEY) ? ST_FEED : ST_MIX;
      ST_MIX: begin
        w_idx_nxt = r_idx + 4'd1;
        if (r_idx == 4'd7) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_MLATCH;
        end
      end
      ST_MLATCH: begin
        w_d_nxt = w_d_inc;
        // A subkey is injected after every fourth round
        if (w_d_inc[1:0] == 2'd0) begin
          w_s_nxt     = r_s + 5'd1;
          w_state_nxt = ST_INJECT;
        end else begin
          w_state_nxt = ST_MIX;
        end
      end
      ST_FEED: begin
        if (!r_blk) begin
          w_blk_nxt   = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_blk_nxt   = 1'b0;
        w_state_nxt = start_i ? ST_LOAD : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  mix_schedule_rom u_mix_rom (
    .i_round      (w_d_nxt[2:0]),
    .i_pair       (w_idx_nxt[2:0]),
    .o_rotate     (w_rot),
    .o_write_mask (w_wmask),
    .o_y1_mask    (w_y1mask)
  );

  // Outputs are decoded from the next state so the registered copy lines up with the state
  always_comb begin
    w_out_nxt = '0;
    w_tweak   = w_blk_nxt ? TWEAK_OUT : TWEAK_MSG;
    if (w_state_nxt != ST_IDLE) begin
      w_out_nxt.busy      = 1'b1;
      w_out_nxt.hash_mode = w_blk_nxt;
    end
    case (w_state_nxt)
      ST_LOAD: begin
        w_out_nxt.output_register_plaintext_select = 1'b1;
        w_out_nxt.input_register_write             = 1'b1;
      end
      ST_INJECT: begin
        w_out_nxt.word                   = w_idx_nxt;
        w_out_nxt.x1_tweak_subkey_select = 2'b10;
        w_out_nxt.subkey                 = w_s_nxt;
        w_out_nxt.subkey_write           = 1'b1;
        w_out_nxt.output_register_write  = 16'd1 << w_idx_nxt;
        w_out_nxt.tweak_word = (w_idx_nxt == 4'd13) ? w_tweak[63:0] : w_tweak[127:64];
      end
      ST_ILATCH, ST_MLATCH: w_out_nxt.input_register_write = 1'b1;
      ST_MIX: begin
        w_out_nxt.word                  = {1'b0, w_idx_nxt[2:0]};
        w_out_nxt.rotate_constant       = w_rot;
        w_out_nxt.output_register_write = w_wmask;
        w_out_nxt.y1_select             = w_y1mask;
      end
      ST_FEED: w_out_nxt.key_register_write = 1'b1;
      ST_DONE: begin
        w_out_nxt.done          = 1'b1;
        w_out_nxt.nonce_advance = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o                             = r_out.busy;
  assign done_o                             = r_out.done;
  assign nonce_advance_o                    = r_out.nonce_advance;
  assign input_register_write_o             = r_out.input_register_write;
  assign word_o                             = r_out.word;
  assign x0_key_select_o                    = r_out.x0_key_select;
  assign x1_tweak_subkey_select_o           = r_out.x1_tweak_subkey_select;
  assign tweak_word_o                       = r_out.tweak_word;
  assign rotate_constant_o                  = r_out.rotate_constant;
  assign Y1_select_o                        = r_out.y1_select;
  assign output_register_write_o            = r_out.output_register_write;
  assign key_register_write_o               = r_out.key_register_write;
  assign hash_mode_o                        = r_out.hash_mode;
  assign subkey_write_o                     = r_out.subkey_write;
  assign output_register_plaintext_select_o = r_out.output_register_plaintext_select;
  assign subkey_o                           = r_out.subkey;
  assign reset_best_nonce_o                 = r_reset_best;

endmodule

// File: tb/tb_skein_core_sequencer.sv
// tb/tb_skein_core_sequencer.sv - Randomized bench against a trace-building reference model
module tb_skein_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_i, start_i, clear_best_i;
  logic        busy_o, done_o, nonce_advance_o, input_register_write_o;
  logic [3:0]  word_o;
  logic        x0_key_select_o;
  logic [1:0]  x1_tweak_subkey_select_o;
  logic [63:0] tweak_word_o;
  logic [5:0]  rotate_constant_o;
  logic [15:0] Y1_select_o, output_register_write_o;
  logic        key_register_write_o, hash_mode_o, subkey_write_o;
  logic        output_register_plaintext_select_o;
  logic [4:0]  subkey_o;
  logic        reset_best_nonce_o;

  always #5 clk = ~clk;

  skein_core_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_best_i(clear_best_i),
    .busy_o(busy_o), .done_o(done_o), .nonce_advance_o(nonce_advance_o),
    .input_register_write_o(input_register_write_o), .word_o(word_o),
    .x0_key_select_o(x0_key_select_o), .x1_tweak_subkey_select_o(x1_tweak_subkey_select_o),
    .tweak_word_o(tweak_word_o), .rotate_constant_o(rotate_constant_o),
    .Y1_select_o(Y1_select_o), .output_register_write_o(output_register_write_o),
    .key_register_write_o(key_register_write_o), .hash_mode_o(hash_mode_o),
    .subkey_write_o(subkey_write_o),
    .output_register_plaintext_select_o(output_register_plaintext_select_o),
    .subkey_o(subkey_o), .reset_best_nonce_o(reset_best_nonce_o)
  );

  typedef struct packed {
    logic busy; logic done; logic adv; logic in_wr;
    logic [3:0] word; logic x0; logic [1:0] x1; logic [63:0] tweak;
    logic [5:0] rot; logic [15:0] y1; logic [15:0] owr;
    logic kwr; logic hash; logic skw; logic pts; logic [4:0] subkey; logic rbn;
  } vec_t;

  localparam logic [127:0] TW_MSG = {64'hF000_0000_0000_0000, 64'h0000_0000_0000_0080};
  localparam logic [127:0] TW_OUT = {64'hFF00_0000_0000_0000, 64'h0000_0000_0000_0008};
  localparam int K_LOAD = 0, K_INJ = 1, K_ILAT = 2, K_MIX = 3, K_MLAT = 4, K_FEED = 5, K_DONE = 6;

  int RT [8][8] = '{
    '{24, 13, 8, 47, 8, 17, 22, 37}, '{38, 19, 10, 55, 49, 18, 23, 52},
    '{33, 4, 51, 13, 34, 41, 59, 17}, '{5, 20, 48, 41, 47, 28, 16, 25},
    '{41, 9, 37, 31, 12, 47, 44, 30}, '{16, 34, 56, 51, 4, 53, 42, 41},
    '{31, 44, 47, 46, 19, 42, 44, 25}, '{9, 48, 35, 52, 23, 31, 37, 20}
  };
  int PI [16] = '{0, 15, 2, 11, 6, 13, 4, 9, 14, 1, 8, 5, 10, 3, 12, 7};

  vec_t q[$];
  vec_t exp_v;
  int   n_vec = 0, n_bad = 0;
  int   ecount = 0, acc_edge = 0;
  int   sk_cnt = 0, kw_cnt = 0;
  int   hist [32];

  task automatic check_eq(input string tag, input logic [127:0] obs_v, input logic [127:0] req_v);
    n_vec++;
    if (obs_v !== req_v) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h, expected %h", tag, ecount, obs_v, req_v);
    end
  endtask

  function automatic vec_t ev(input int kind, input int blk, input int s, input int i, input int d);
    vec_t e;
    logic [127:0] tw;
    e = '0;
    e.busy = 1'b1;
    e.hash = 1'(blk);
    tw = (blk != 0) ? TW_OUT : TW_MSG;
    case (kind)
      K_LOAD: begin e.pts = 1'b1; e.in_wr = 1'b1; end
      K_INJ: begin
        e.word = 4'(i); e.x1 = 2'b10; e.subkey = 5'(s); e.skw = 1'b1;
        e.owr = 16'd1 << i;
        e.tweak = (i == 13) ? tw[63:0] : tw[127:64];
      end
      K_ILAT, K_MLAT: e.in_wr = 1'b1;
      K_MIX: begin
        e.word = 4'(i);
        e.rot  = 6'(RT[d % 8][i]);
        e.y1   = 16'd1 << PI[2*i+1];
        e.owr  = e.y1 | (16'd1 << PI[2*i]);
      end
      K_FEED: e.kwr = 1'b1;
      K_DONE: begin e.done = 1'b1; e.adv = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // One full evaluation as a flat list of per-cycle expectations
  task automatic push_eval();
    for (int b = 0; b < 2; b++) begin
      q.push_back(ev(K_LOAD, b, 0, 0, 0));
      for (int s = 0; s <= 20; s++) begin
        for (int i = 0; i < 16; i++) q.push_back(ev(K_INJ, b, s, i, 0));
        q.push_back(ev(K_ILAT, b, 0, 0, 0));
        if (s < 20) begin
          for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 8; p++) q.push_back(ev(K_MIX, b, 0, p, 4*s + r));
            q.push_back(ev(K_MLAT, b, 0, 0, 0));
          end
        end
      end
      q.push_back(ev(K_FEED, b, 0, 0, 0));
    end
    q.push_back(ev(K_DONE, 1, 0, 0, 0));
  endtask

  task automatic clear_counts();
    sk_cnt = 0;
    kw_cnt = 0;
    for (int k = 0; k < 32; k++) hist[k] = 0;
  endtask

  task automatic step(input logic r, input logic st, input logic cl);
    vec_t obs;
    rst_i = r; start_i = st; clear_best_i = cl;
    @(posedge clk);
    ecount++;
    if (!r) begin
      q.delete();
      exp_v = '0;
    end else begin
      if (q.size() == 0 && st) begin
        push_eval();
        acc_edge = ecount;
      end
      if (q.size() > 0) exp_v = q.pop_front();
      else exp_v = '0;
      exp_v.rbn = cl;
    end
    @(negedge clk);
    obs = {busy_o, done_o, nonce_advance_o, input_register_write_o, word_o, x0_key_select_o,
           x1_tweak_subkey_select_o, tweak_word_o, rotate_constant_o, Y1_select_o,
           output_register_write_o, key_register_write_o, hash_mode_o, subkey_write_o,
           output_register_plaintext_select_o, subkey_o, reset_best_nonce_o};
    check_eq("outputs", 128'(obs), 128'(exp_v));
    if (!r) begin
      clear_counts();
    end else begin
      if (q.size() > 0 && ecount - acc_edge == 18) begin
        check_eq("mix0_rot", 128'(rotate_constant_o), 128'(24));
        check_eq("mix0_wmask", 128'(output_register_write_o), 128'(16'h8001));
        check_eq("mix0_y1", 128'(Y1_select_o), 128'(16'h8000));
      end
      if (subkey_write_o) begin
        sk_cnt++;
        hist[subkey_o]++;
      end
      if (key_register_write_o) kw_cnt++;
      if (done_o) begin
        check_eq("done_latency", 128'(ecount - acc_edge), 128'(2158));
        check_eq("subkey_writes", 128'(sk_cnt), 128'(672));
        check_eq("key_writes", 128'(kw_cnt), 128'(2));
        for (int k = 0; k <= 20; k++) check_eq("subkey_hist", 128'(hist[k]), 128'(32));
        clear_counts();
      end
    end
  endtask

  task automatic run_eval(input int abort_at);
    int n;
    n = 0;
    while (q.size() > 0 && n < 2300) begin
      if (abort_at != 0 && n == abort_at) begin
        step(1'b0, 1'b0, 1'b1);
        return;
      end
      step(1'b1, ($urandom % 16) == 0, (n == 300) || (($urandom % 8) == 0));
      n++;
    end
    if (q.size() > 0) check_eq("eval_timeout", 128'(q.size()), 128'(0));
  endtask

  initial begin
    int gap;
    rst_i = 1'b0; start_i = 1'b0; clear_best_i = 1'b0;
    clear_counts();
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 5; e++) begin
      gap = (e == 2 || e == 3) ? 0 : $urandom_range(1, 12);
      repeat (gap) step(1'b1, 1'b0, ($urandom % 4) == 0);
      step(1'b1, 1'b1, ($urandom % 4) == 0);
      run_eval((e == 3) ? 500 : 0);
    end
    repeat (5) step(1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
